// File: rtl/instruction_fetch_if.sv
// rtl/instruction_fetch_if.sv - instruction-memory request/response bundle
// Purpose: groups the fetch-stage <-> instruction-memory handshake.
// Signals:
//   imem_req   fetch request (fetch stage -> memory)
//   imem_addr  word-aligned fetch address (fetch stage -> memory)
//   imem_ready imem_rdata valid for imem_addr this cycle (memory -> fetch stage)
//   imem_rdata instruction word (memory -> fetch stage)
// Modports: master = fetch stage, slave = instruction memory.
interface instruction_fetch_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic [31:0] imem_rdata;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_ready,
    input  imem_rdata
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_ready,
    output imem_rdata
  );
endinterface

// File: rtl/instruction_fetch.sv
// rtl/instruction_fetch.sv - fetch stage: PC, imem handshake, stall hold, redirect
// Purpose: owns the program counter, fetches one word per cycle when memory is
// ready, parks a word in a hold buffer while the IF/ID register is stalled, and
// restarts from a redirect target on branch/jump.
// Ports:
//   i_clk            clock, all state updates on rising edge
//   i_reset          synchronous active-high reset
//   i_stall          downstream cannot accept; hold current instruction
//   i_redirect_valid branch/jump taken this cycle
//   i_redirect_pc    redirect target, bits [1:0] ignored
//   imem             instruction-memory handshake (master side)
//   o_instr_out      instruction to IF/ID
//   o_pc_out         PC of o_instr_out
//   o_pc_plus4_out   o_pc_out + PC_STEP
//   o_instr_valid    IF/ID write enable; instruction accepted this cycle
module instruction_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          PC_STEP  = 4
) (
  input  logic                   i_clk,
  input  logic                   i_reset,
  input  logic                   i_stall,
  input  logic                   i_redirect_valid,
  input  logic [31:0]            i_redirect_pc,
  instruction_fetch_if.master    imem,
  output logic [31:0]            o_instr_out,
  output logic [31:0]            o_pc_out,
  output logic [31:0]            o_pc_plus4_out,
  output logic                   o_instr_valid
);

  typedef enum logic {
    S_FETCH = 1'b0,
    S_HOLD  = 1'b1
  } state_t;

  localparam logic [31:0] STEP             = 32'(PC_STEP);
  localparam logic [31:0] RESET_PC_ALIGNED = RESET_PC & ~32'h3;

  state_t      r_state;
  logic [31:0] r_pc;
  logic [31:0] r_hold_buf;

  // Masking keeps every redirect bit "used" while forcing word alignment.
  logic [31:0] w_redirect_target;
  logic [31:0] w_pc_next;
  logic        w_in_fetch;
  logic        w_accept;

  assign w_redirect_target = i_redirect_pc & ~32'h3;
  assign w_pc_next         = r_pc + STEP;
  assign w_in_fetch        = (r_state == S_FETCH);
  // An instruction is handed to IF/ID when one is available (fresh from
  // memory or parked in the hold buffer) and nothing blocks or squashes it.
  assign w_accept = !i_redirect_valid && !i_stall &&
                    ((w_in_fetch && imem.imem_ready) || !w_in_fetch);

  always_comb begin
    imem.imem_addr = r_pc;
    imem.imem_req  = 1'b0;
    o_instr_out    = 32'h0;
    o_pc_out       = 32'h0;
    o_pc_plus4_out = 32'h0;
    o_instr_valid  = 1'b0;
    if (!i_reset) begin
      imem.imem_req  = w_in_fetch;
      o_instr_out    = w_in_fetch ? imem.imem_rdata : r_hold_buf;
      o_pc_out       = r_pc;
      o_pc_plus4_out = w_pc_next;
      o_instr_valid  = w_accept;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state    <= S_FETCH;
      r_pc       <= RESET_PC_ALIGNED;
      r_hold_buf <= 32'h0;
    end else if (i_redirect_valid) begin
      // Any word arriving this cycle and any parked word belong to the
      // squashed path; the hold buffer is simply abandoned.
      r_state <= S_FETCH;
      r_pc    <= w_redirect_target;
    end else begin
      case (r_state)
        S_FETCH: begin
          if (imem.imem_ready) begin
            if (i_stall) begin
              r_hold_buf <= imem.imem_rdata;
              r_state    <= S_HOLD;
            end else begin
              r_pc <= w_pc_next;
            end
          end
        end
        S_HOLD: begin
          if (!i_stall) begin
            r_pc    <= w_pc_next;
            r_state <= S_FETCH;
          end
        end
        default: r_state <= S_FETCH;
      endcase
    end
  end

endmodule

// File: tb/tb_instruction_fetch.sv
// tb/tb_instruction_fetch.sv - randomized self-checking bench for instruction_fetch
module tb_instruction_fetch;

  localparam logic [31:0] KEY = 32'hA5A5_A5A5;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall;
  logic        rv;
  logic [31:0] rpc;
  logic [31:0] instr_out;
  logic [31:0] pc_out;
  logic [31:0] pc4_out;
  logic        instr_valid;

  int total = 0;
  int bad   = 0;

  instruction_fetch_if bus ();

  instruction_fetch #(
    .RESET_PC(32'h0000_0000),
    .PC_STEP (4)
  ) dut (
    .i_clk           (clk),
    .i_reset         (rst),
    .i_stall         (stall),
    .i_redirect_valid(rv),
    .i_redirect_pc   (rpc),
    .imem            (bus.master),
    .o_instr_out     (instr_out),
    .o_pc_out        (pc_out),
    .o_pc_plus4_out  (pc4_out),
    .o_instr_valid   (instr_valid)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
    end
  endtask

  // One clock of stimulus: inputs change 1ns after the rising edge; memory
  // data is the address-derived word unless an explicit word is supplied.
  task automatic cyc(input logic r, input logic s, input logic v, input logic [31:0] p,
                     input logic rdy, input logic ov, input logic [31:0] word);
    @(posedge clk);
    #1;
    rst            = r;
    stall          = s;
    rv             = v;
    rpc            = p;
    bus.imem_ready = rdy;
    bus.imem_rdata = ov ? word : (bus.imem_addr ^ KEY);
    #1;
  endtask

  // Reference model: the PC of the next instruction owed to IF/ID and, if
  // one was fetched but refused, that word.
  logic [31:0] m_pc;
  logic        m_parked;
  logic [31:0] m_word;
  logic        m_known = 1'b0;

  always @(negedge clk) begin
    logic        e_valid;
    logic [31:0] e_instr;
    if (rst) begin
      chk("rst_req",   {31'b0, bus.imem_req}, 32'h0);
      chk("rst_valid", {31'b0, instr_valid},  32'h0);
      chk("rst_instr", instr_out,             32'h0);
      chk("rst_pc",    pc_out,                32'h0);
      chk("rst_pc4",   pc4_out,               32'h0);
      m_pc     = 32'h0;
      m_parked = 1'b0;
      m_known  = 1'b1;
    end else if (m_known) begin
      e_valid = !rv && !stall && (m_parked || bus.imem_ready);
      e_instr = m_parked ? m_word : bus.imem_rdata;
      chk("addr",  bus.imem_addr,         m_pc);
      chk("req",   {31'b0, bus.imem_req}, {31'b0, !m_parked});
      chk("valid", {31'b0, instr_valid},  {31'b0, e_valid});
      chk("instr", instr_out,             e_instr);
      chk("pc",    pc_out,                m_pc);
      chk("pc4",   pc4_out,               m_pc + 32'd4);
      if (rv) begin
        m_pc     = rpc & ~32'h3;
        m_parked = 1'b0;
      end else if (e_valid) begin
        m_pc     = m_pc + 32'd4;
        m_parked = 1'b0;
      end else if (!m_parked && bus.imem_ready && stall) begin
        m_parked = 1'b1;
        m_word   = bus.imem_rdata;
      end
    end
  end

  initial begin
    rst            = 1'b1;
    stall          = 1'b0;
    rv             = 1'b0;
    rpc            = 32'h0;
    bus.imem_ready = 1'b0;
    bus.imem_rdata = 32'h0;

    cyc(1, 0, 0, 0, 1, 0, 0);
    cyc(1, 0, 0, 0, 1, 0, 0);
    chk("lit_rst_valid", {31'b0, instr_valid}, 32'h0);

    // Back-to-back fetches from 0.
    for (int i = 0; i < 2; i++) begin
      cyc(0, 0, 0, 0, 1, 0, 0);
      chk("lit_seq_pc",    pc_out,    32'(i * 4));
      chk("lit_seq_pc4",   pc4_out,   32'(i * 4 + 4));
      chk("lit_seq_instr", instr_out, 32'(i * 4) ^ KEY);
      chk("lit_seq_valid", {31'b0, instr_valid}, 32'h1);
    end

    // Memory wait states at pc=8.
    for (int i = 0; i < 3; i++) begin
      cyc(0, 0, 0, 0, 0, 0, 0);
      chk("lit_wait_addr",  bus.imem_addr, 32'h8);
      chk("lit_wait_req",   {31'b0, bus.imem_req}, 32'h1);
      chk("lit_wait_valid", {31'b0, instr_valid}, 32'h0);
    end
    cyc(0, 0, 0, 0, 1, 0, 0);
    chk("lit_wait_done_valid", {31'b0, instr_valid}, 32'h1);
    chk("lit_wait_done_pc",    pc_out, 32'h8);

    // Stall the word arriving at pc=12 and release after two more cycles.
    cyc(0, 1, 0, 0, 1, 1, 32'h8C22_0004);
    chk("lit_hold_enter_valid", {31'b0, instr_valid}, 32'h0);
    for (int i = 0; i < 2; i++) begin
      cyc(0, 1, 0, 0, 1, 1, 32'hDEAD_BEEF);
      chk("lit_hold_req",   {31'b0, bus.imem_req}, 32'h0);
      chk("lit_hold_valid", {31'b0, instr_valid}, 32'h0);
    end
    cyc(0, 0, 0, 0, 1, 1, 32'hDEAD_BEEF);
    chk("lit_release_instr", instr_out, 32'h8C22_0004);
    chk("lit_release_pc",    pc_out,    32'hC);
    chk("lit_release_valid", {31'b0, instr_valid}, 32'h1);
    cyc(0, 0, 0, 0, 0, 0, 0);
    chk("lit_after_release_addr", bus.imem_addr, 32'h10);

    // Redirect squashes a stalled incoming word.
    cyc(0, 1, 1, 32'h0000_0043, 1, 0, 0);
    chk("lit_redir_valid", {31'b0, instr_valid}, 32'h0);
    cyc(0, 0, 0, 0, 0, 0, 0);
    chk("lit_redir_addr", bus.imem_addr, 32'h40);

    // PC wrap-around.
    cyc(0, 0, 1, 32'hFFFF_FFFE, 0, 0, 0);
    cyc(0, 0, 0, 0, 1, 0, 0);
    chk("lit_wrap_pc",  pc_out,  32'hFFFF_FFFC);
    chk("lit_wrap_pc4", pc4_out, 32'h0);
    cyc(0, 0, 0, 0, 0, 0, 0);
    chk("lit_wrap_addr", bus.imem_addr, 32'h0);

    // Reset while a word is parked.
    cyc(0, 0, 1, 32'h0000_0100, 0, 0, 0);
    cyc(0, 1, 0, 0, 1, 0, 0);
    cyc(0, 1, 0, 0, 1, 0, 0);
    chk("lit_hold_before_rst_req", {31'b0, bus.imem_req}, 32'h0);
    cyc(1, 1, 0, 0, 1, 0, 0);
    cyc(0, 0, 0, 0, 0, 0, 0);
    chk("lit_post_rst_addr", bus.imem_addr, 32'h0);
    chk("lit_post_rst_req",  {31'b0, bus.imem_req}, 32'h1);
    cyc(0, 0, 0, 0, 1, 1, 32'h1234_5678);
    chk("lit_post_rst_instr", instr_out, 32'h1234_5678);

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      cyc(($urandom_range(0, 99) < 1),
          ($urandom_range(0, 99) < 30),
          ($urandom_range(0, 99) < 8),
          $urandom(),
          ($urandom_range(0, 99) < 70),
          ($urandom_range(0, 99) < 50),
          $urandom());
    end

    @(posedge clk);
    #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
